// File: rtl/spi_frame_tx.sv
// spi_frame_tx: mode-0 SPI master that shifts one WIDTH-bit word out on sdo, MSB first, capturing sdi
module spi_frame_tx #(
    parameter int WIDTH   = 16,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] tx_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rx_data,
    output logic             cs,
    output logic             sck,
    output logic             sdo,
    input  logic             sdi
);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BITS_ALL = BW'(WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_DONE} state_t;

    state_t           state, state_n;
    logic [DW-1:0]    div, div_n;
    logic [BW-1:0]    bits, bits_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [WIDTH-1:0] rxsh, rxsh_n;
    logic [WIDTH-1:0] rx_data_n;
    logic             cs_n, sck_n, sdo_n, busy_n, done_n;
    logic             wrap;
    logic [DW-1:0]    div_step;

    assign wrap     = div == DIV_LAST;
    assign div_step = wrap ? '0 : div + 1'b1;

    // Next-state and next-output logic; every output is a flop fed from here
    always_comb begin
        state_n   = state;
        div_n     = div;
        bits_n    = bits;
        shreg_n   = shreg;
        rxsh_n    = rxsh;
        rx_data_n = rx_data;
        cs_n      = cs;
        sck_n     = sck;
        sdo_n     = sdo;
        busy_n    = busy;
        done_n    = 1'b0;
        case (state)
            S_IDLE: begin
                cs_n   = 1'b0;
                sck_n  = 1'b0;
                busy_n = 1'b0;
                if (start) begin
                    state_n = S_SETUP;
                    shreg_n = tx_data;
                    sdo_n   = tx_data[WIDTH-1];
                    rxsh_n  = '0;
                    div_n   = '0;
                    bits_n  = BITS_ALL;
                    cs_n    = 1'b1;
                    busy_n  = 1'b1;
                end
            end
            S_SETUP: begin
                div_n = div_step;
                if (wrap) state_n = S_SHIFT;
            end
            S_SHIFT: begin
                div_n = div_step;
                if (wrap) begin
                    sck_n = ~sck;
                    if (!sck) begin
                        rxsh_n = {rxsh[WIDTH-2:0], sdi};
                        bits_n = bits - 1'b1;
                    end else if (bits != '0) begin
                        shreg_n = {shreg[WIDTH-2:0], 1'b0};
                        sdo_n   = shreg[WIDTH-2];
                    end else begin
                        state_n = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                div_n = div_step;
                if (wrap) begin
                    state_n   = S_DONE;
                    cs_n      = 1'b0;
                    done_n    = 1'b1;
                    rx_data_n = rxsh;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State and output registers; reset drops cs/sck at once, aborting any frame without done
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            div     <= '0;
            bits    <= '0;
            shreg   <= '0;
            rxsh    <= '0;
            rx_data <= '0;
            cs      <= 1'b0;
            sck     <= 1'b0;
            sdo     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            div     <= div_n;
            bits    <= bits_n;
            shreg   <= shreg_n;
            rxsh    <= rxsh_n;
            rx_data <= rx_data_n;
            cs      <= cs_n;
            sck     <= sck_n;
            sdo     <= sdo_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

endmodule

// File: tb/tb_spi_frame_tx.sv
// tb_spi_frame_tx: randomized self-checking bench for spi_frame_tx against a frame-level reference model
module tb_spi_frame_tx;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        a_start = 1'b0, a_sdi = 1'b0;
    logic [15:0] a_tx = '0;
    logic        a_busy, a_done, a_cs, a_sck, a_sdo;
    logic [15:0] a_rx;

    logic        b_start = 1'b0, b_sdi = 1'b0;
    logic [7:0]  b_tx = '0;
    logic        b_busy, b_done, b_cs, b_sck, b_sdo;
    logic [7:0]  b_rx;

    spi_frame_tx #(.WIDTH(16), .CLK_DIV(2)) dut_a (
        .clk(clk), .reset(reset), .start(a_start), .tx_data(a_tx), .busy(a_busy), .done(a_done),
        .rx_data(a_rx), .cs(a_cs), .sck(a_sck), .sdo(a_sdo), .sdi(a_sdi)
    );

    spi_frame_tx #(.WIDTH(8), .CLK_DIV(1)) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .tx_data(b_tx), .busy(b_busy), .done(b_done),
        .rx_data(b_rx), .cs(b_cs), .sck(b_sck), .sdo(b_sdo), .sdi(b_sdi)
    );

    int errors = 0;
    int checks = 0;

    // Frame model for WIDTH=16, CLK_DIV=2: cs high 2*(2*16+2)=68 cycles, done one cycle later
    localparam int A_CS_CYC = 68;
    localparam int A_DONE_K = 69;

    int          o_cs_hi, o_first_cs, o_last_cs, o_rises, o_done_cnt, o_done_k, o_busy_last, o_sdo_bad;
    logic [15:0] o_sdo_bits;

    // Watches dut_a for n cycles after an accept edge, feeding sdi MSB first (or looping sdo back)
    task automatic observe_a(input logic [15:0] sdi_word, input bit loop, input int n, input int mid_k);
        logic psck, psdo;
        o_cs_hi = 0; o_first_cs = 0; o_last_cs = 0; o_rises = 0;
        o_done_cnt = 0; o_done_k = 0; o_busy_last = 0; o_sdo_bad = 0; o_sdo_bits = '0;
        psck = 1'b0;
        psdo = a_sdo;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (k == 1) a_start = 1'b0;
            if (mid_k > 0 && k == mid_k) begin
                a_start = 1'b1;
                a_tx = 16'hFFFF;
            end
            if (mid_k > 0 && k == mid_k + 1) a_start = 1'b0;
            if (a_cs) begin
                o_cs_hi++;
                if (o_first_cs == 0) o_first_cs = k;
                o_last_cs = k;
            end
            if (a_done) begin
                o_done_cnt++;
                o_done_k = k;
            end
            if (a_busy) o_busy_last = k;
            if (k != 1 && a_sdo !== psdo && !(psck && !a_sck)) o_sdo_bad++;
            if (!psck && a_sck) begin
                o_sdo_bits = {o_sdo_bits[14:0], a_sdo};
                o_rises++;
            end
            a_sdi = loop ? a_sdo : (o_rises < 16 ? sdi_word[15 - o_rises] : 1'b0);
            psck = a_sck;
            psdo = a_sdo;
        end
    endtask

    task automatic launch_a(input logic [15:0] tx, input logic [15:0] sdi_word, input bit loop);
        @(negedge clk);
        a_tx = tx;
        a_sdi = loop ? a_sdo : sdi_word[15];
        a_start = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (a_cs !== 1'b0 || a_sck !== 1'b0 || a_sdo !== 1'b0) begin errors++; $display("FAIL reset_a_pins: cs=%b sck=%b sdo=%b want 000", a_cs, a_sck, a_sdo); end
        checks++; if (a_busy !== 1'b0 || a_done !== 1'b0) begin errors++; $display("FAIL reset_a_flags: busy=%b done=%b want 00", a_busy, a_done); end
        checks++; if (a_rx !== 16'h0) begin errors++; $display("FAIL reset_a_rx: got %h want 0000", a_rx); end
        checks++; if (b_cs !== 1'b0 || b_sck !== 1'b0 || b_sdo !== 1'b0 || b_busy !== 1'b0 || b_done !== 1'b0 || b_rx !== 8'h0) begin errors++; $display("FAIL reset_b: cs=%b sck=%b sdo=%b busy=%b done=%b rx=%h want all 0", b_cs, b_sck, b_sdo, b_busy, b_done, b_rx); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_known_frame;
        logic [15:0] sw;
        sw = 16'($urandom);
        launch_a(16'hA5C3, sw, 1'b0);
        observe_a(sw, 1'b0, 72, 0);
        checks++; if (o_rises !== 16) begin errors++; $display("FAIL known_rises: got %0d want 16", o_rises); end
        checks++; if (o_sdo_bits !== 16'hA5C3) begin errors++; $display("FAIL known_sdo: got %h want a5c3", o_sdo_bits); end
        checks++; if (o_cs_hi !== A_CS_CYC || o_first_cs !== 1 || o_last_cs !== A_CS_CYC) begin errors++; $display("FAIL known_cs: high=%0d first=%0d last=%0d want %0d/1/%0d", o_cs_hi, o_first_cs, o_last_cs, A_CS_CYC, A_CS_CYC); end
        checks++; if (o_done_cnt !== 1 || o_done_k !== A_DONE_K) begin errors++; $display("FAIL known_done: count=%0d at=%0d want 1 at %0d", o_done_cnt, o_done_k, A_DONE_K); end
        checks++; if (o_busy_last !== A_DONE_K) begin errors++; $display("FAIL known_busy: last high=%0d want %0d", o_busy_last, A_DONE_K); end
        checks++; if (o_sdo_bad !== 0) begin errors++; $display("FAIL known_sdo_timing: %0d changes off falling edges, want 0", o_sdo_bad); end
        checks++; if (a_rx !== sw) begin errors++; $display("FAIL known_rx: got %h want %h", a_rx, sw); end
    endtask

    task automatic test_loopback;
        launch_a(16'h3C5A, 16'h0, 1'b1);
        observe_a(16'h0, 1'b1, 72, 0);
        checks++; if (a_rx !== 16'h3C5A) begin errors++; $display("FAIL loop_rx: got %h want 3c5a", a_rx); end
        @(negedge clk);
        a_tx = 16'h9999;
        a_sdi = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (a_rx !== 16'h3C5A || a_cs !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL loop_rx_hold: rx=%h cs=%b busy=%b want 3c5a 0 0", a_rx, a_cs, a_busy); end
    endtask

    task automatic test_ignore_start;
        launch_a(16'h0001, 16'hC0DE, 1'b0);
        observe_a(16'hC0DE, 1'b0, 80, 20);
        checks++; if (o_rises !== 16 || o_sdo_bits !== 16'h0001) begin errors++; $display("FAIL ignore_sdo: rises=%0d bits=%h want 16 0001", o_rises, o_sdo_bits); end
        checks++; if (o_done_cnt !== 1 || o_cs_hi !== A_CS_CYC) begin errors++; $display("FAIL ignore_frames: done=%0d cs_high=%0d want 1 %0d", o_done_cnt, o_cs_hi, A_CS_CYC); end
        checks++; if (a_rx !== 16'hC0DE) begin errors++; $display("FAIL ignore_rx: got %h want c0de", a_rx); end
    endtask

    task automatic test_random;
        logic [15:0] tx, sw;
        for (int i = 0; i < 8; i++) begin
            tx = 16'($urandom);
            sw = 16'($urandom);
            launch_a(tx, sw, 1'b0);
            observe_a(sw, 1'b0, 71, 0);
            checks++; if (o_sdo_bits !== tx || o_rises !== 16) begin errors++; $display("FAIL rand_sdo[%0d]: bits=%h rises=%0d want %h 16", i, o_sdo_bits, o_rises, tx); end
            checks++; if (a_rx !== sw) begin errors++; $display("FAIL rand_rx[%0d]: got %h want %h", i, a_rx, sw); end
            checks++; if (o_done_k !== A_DONE_K || o_cs_hi !== A_CS_CYC) begin errors++; $display("FAIL rand_timing[%0d]: done_at=%0d cs_high=%0d want %0d %0d", i, o_done_k, o_cs_hi, A_DONE_K, A_CS_CYC); end
        end
    endtask

    task automatic test_reset_mid;
        int rises, dones;
        logic psck;
        bit hit;
        rises = 0; dones = 0; psck = 1'b0; hit = 1'b0;
        launch_a(16'hF00F, 16'h0, 1'b0);
        for (int k = 1; k <= 100 && !hit; k++) begin
            @(negedge clk);
            if (k == 1) a_start = 1'b0;
            if (!psck && a_sck) rises++;
            psck = a_sck;
            if (rises == 5) hit = 1'b1;
        end
        checks++; if (!hit) begin errors++; $display("FAIL midreset_reach: rises=%0d want 5 within 100 cycles", rises); end
        reset = 1'b0;
        #1;
        checks++; if (a_cs !== 1'b0 || a_sck !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL midreset_drop: cs=%b sck=%b busy=%b want 000", a_cs, a_sck, a_busy); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (a_done) dones++;
        end
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (a_done) dones++;
        end
        checks++; if (dones !== 0) begin errors++; $display("FAIL midreset_nodone: got %0d done pulses want 0", dones); end
        launch_a(16'h5AA5, 16'h1357, 1'b0);
        observe_a(16'h1357, 1'b0, 72, 0);
        checks++; if (o_rises !== 16 || o_sdo_bits !== 16'h5AA5 || o_done_cnt !== 1) begin errors++; $display("FAIL midreset_after: rises=%0d bits=%h dones=%0d want 16 5aa5 1", o_rises, o_sdo_bits, o_done_cnt); end
        checks++; if (a_rx !== 16'h1357) begin errors++; $display("FAIL midreset_rx: got %h want 1357", a_rx); end
    endtask

    task automatic test_back_to_back;
        int dones, cs_hi, rises, fall_k, gap;
        logic pcs, psck;
        logic [31:0] bits;
        dones = 0; cs_hi = 0; rises = 0; fall_k = 0; gap = -1; pcs = 1'b0; psck = 1'b0; bits = '0;
        launch_a(16'h1234, 16'h0, 1'b0);
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk);
            if (k == 100) a_start = 1'b0;
            if (a_done) dones++;
            if (a_cs) cs_hi++;
            if (pcs && !a_cs) fall_k = k;
            if (!pcs && a_cs && fall_k > 0 && gap < 0) gap = k - fall_k;
            if (!psck && a_sck) begin
                bits = {bits[30:0], a_sdo};
                rises++;
            end
            pcs = a_cs;
            psck = a_sck;
        end
        checks++; if (gap !== 2) begin errors++; $display("FAIL b2b_gap: cs low %0d cycles want 2", gap); end
        checks++; if (dones !== 2 || cs_hi !== 2 * A_CS_CYC) begin errors++; $display("FAIL b2b_frames: dones=%0d cs_high=%0d want 2 %0d", dones, cs_hi, 2 * A_CS_CYC); end
        checks++; if (rises !== 32 || bits !== 32'h12341234) begin errors++; $display("FAIL b2b_sdo: rises=%0d bits=%h want 32 12341234", rises, bits); end
    endtask

    task automatic test_narrow;
        int cs_hi, rises, first_r, last_r, done_k;
        logic psck;
        logic [7:0] bits;
        cs_hi = 0; rises = 0; first_r = 0; last_r = 0; done_k = 0; psck = 1'b0; bits = '0;
        @(negedge clk);
        b_tx = 8'h81;
        b_start = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (k == 1) b_start = 1'b0;
            if (b_cs) cs_hi++;
            if (b_done) done_k = k;
            if (!psck && b_sck) begin
                bits = {bits[6:0], b_sdo};
                rises++;
                if (first_r == 0) first_r = k;
                last_r = k;
            end
            psck = b_sck;
        end
        checks++; if (cs_hi !== 18) begin errors++; $display("FAIL narrow_cs: high %0d want 18", cs_hi); end
        checks++; if (rises !== 8 || bits !== 8'h81) begin errors++; $display("FAIL narrow_sdo: rises=%0d bits=%h want 8 81", rises, bits); end
        checks++; if (last_r - first_r !== 14) begin errors++; $display("FAIL narrow_period: rise span %0d want 14", last_r - first_r); end
        checks++; if (done_k !== 19) begin errors++; $display("FAIL narrow_done: at %0d want 19", done_k); end
    endtask

    initial begin
        test_reset;
        test_known_frame;
        test_loopback;
        test_ignore_start;
        test_random;
        test_reset_mid;
        test_back_to_back;
        test_narrow;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
